// File: rtl/ex_mem_stage_buf_if.sv
// EX -> MEM stage bundle: EX-side inputs, flush, MEM-side handshake and head fields.
// The master modport drives the EX side; the slave modport is the stage buffer itself.
interface ex_mem_stage_buf_if #(
    parameter int NBits    = 32,
    parameter int RegAddrW = 5,
    parameter int CntW     = 16
);
    logic                in_valid_i;
    logic                in_ready_o;
    logic [NBits-1:0]    ID_EX_pc_4_i;
    logic [NBits-1:0]    pc_immediate_i;
    logic                zero_i;
    logic [NBits-1:0]    alu_result_i;
    logic [NBits-1:0]    ID_EX_read_2_i;
    logic [RegAddrW-1:0] ID_EX_write_register_i;
    logic                ID_EX_reg_write_i;
    logic                ID_EX_jalr_i;
    logic                ID_EX_branch_i;
    logic                ID_EX_mem_read_i;
    logic                ID_EX_mem_write_i;
    logic [1:0]          ID_EX_mem_to_reg_i;
    logic                flush_i;
    logic                out_ready_i;
    logic                out_valid_o;
    logic [NBits-1:0]    EX_MEM_pc_4_o;
    logic [NBits-1:0]    EX_MEM_pc_o;
    logic [NBits-1:0]    EX_MEM_alu_result_o;
    logic [NBits-1:0]    EX_MEM_write_data_o;
    logic                EX_MEM_zero_o;
    logic [RegAddrW-1:0] EX_MEM_write_register_o;
    logic [1:0]          EX_MEM_mem_to_reg_o;
    logic                EX_MEM_reg_write_o;
    logic                EX_MEM_jalr_o;
    logic                EX_MEM_branch_o;
    logic                EX_MEM_mem_read_o;
    logic                EX_MEM_mem_write_o;
    logic                EX_MEM_branch_taken_o;
    logic [CntW-1:0]     stall_cnt_o;

    modport master (
        output in_valid_i, ID_EX_pc_4_i, pc_immediate_i, zero_i, alu_result_i,
               ID_EX_read_2_i, ID_EX_write_register_i, ID_EX_reg_write_i, ID_EX_jalr_i,
               ID_EX_branch_i, ID_EX_mem_read_i, ID_EX_mem_write_i, ID_EX_mem_to_reg_i,
               flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, EX_MEM_pc_4_o, EX_MEM_pc_o, EX_MEM_alu_result_o,
               EX_MEM_write_data_o, EX_MEM_zero_o, EX_MEM_write_register_o,
               EX_MEM_mem_to_reg_o, EX_MEM_reg_write_o, EX_MEM_jalr_o, EX_MEM_branch_o,
               EX_MEM_mem_read_o, EX_MEM_mem_write_o, EX_MEM_branch_taken_o, stall_cnt_o
    );

    modport slave (
        input  in_valid_i, ID_EX_pc_4_i, pc_immediate_i, zero_i, alu_result_i,
               ID_EX_read_2_i, ID_EX_write_register_i, ID_EX_reg_write_i, ID_EX_jalr_i,
               ID_EX_branch_i, ID_EX_mem_read_i, ID_EX_mem_write_i, ID_EX_mem_to_reg_i,
               flush_i, out_ready_i,
        output in_ready_o, out_valid_o, EX_MEM_pc_4_o, EX_MEM_pc_o, EX_MEM_alu_result_o,
               EX_MEM_write_data_o, EX_MEM_zero_o, EX_MEM_write_register_o,
               EX_MEM_mem_to_reg_o, EX_MEM_reg_write_o, EX_MEM_jalr_o, EX_MEM_branch_o,
               EX_MEM_mem_read_o, EX_MEM_mem_write_o, EX_MEM_branch_taken_o, stall_cnt_o
    );
endinterface

// File: rtl/ex_mem_stage_buf.sv
// EX/MEM elastic buffer of DEPTH entries; 1-cycle latency, no bypass, flush empties it.
// Backpressure: accepts when not full or when MEM pops the head in the same cycle.
module ex_mem_stage_buf #(
    parameter int NBits    = 32,
    parameter int RegAddrW = 5,
    parameter int DEPTH    = 2,
    parameter int CntW     = 16
) (
    input  logic             clk,
    input  logic             reset,
    ex_mem_stage_buf_if.slave bus
);
    localparam int PtrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CountW = $clog2(DEPTH) + 1;
    localparam logic [CountW-1:0] DepthC = CountW'(DEPTH);

    typedef struct packed {
        logic [NBits-1:0]    pc_4;
        logic [NBits-1:0]    pc;
        logic [NBits-1:0]    alu_result;
        logic [NBits-1:0]    write_data;
        logic                zero;
        logic [RegAddrW-1:0] write_register;
        logic [1:0]          mem_to_reg;
        logic                reg_write;
        logic                jalr;
        logic                branch;
        logic                mem_read;
        logic                mem_write;
        logic                branch_taken;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            in_entry;
    entry_t            head;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CountW-1:0] count_q, count_d;
    logic [CntW-1:0]   stall_q, stall_d;
    logic              push, pop, out_valid, in_ready;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (DEPTH == 1) return '0;
        return p + 1'b1;
    endfunction

    always_comb begin
        in_entry                = '0;
        in_entry.pc_4           = bus.ID_EX_pc_4_i;
        in_entry.pc             = bus.pc_immediate_i;
        in_entry.alu_result     = bus.alu_result_i;
        in_entry.write_data     = bus.ID_EX_read_2_i;
        in_entry.zero           = bus.zero_i;
        in_entry.write_register = bus.ID_EX_write_register_i;
        in_entry.mem_to_reg     = bus.ID_EX_mem_to_reg_i;
        in_entry.reg_write      = bus.ID_EX_reg_write_i;
        in_entry.jalr           = bus.ID_EX_jalr_i;
        in_entry.branch         = bus.ID_EX_branch_i;
        in_entry.mem_read       = bus.ID_EX_mem_read_i;
        in_entry.mem_write      = bus.ID_EX_mem_write_i;
        // Branch outcome is resolved once at push so MEM sees a single registered bit.
        in_entry.branch_taken   = bus.ID_EX_branch_i & bus.zero_i;
    end

    assign out_valid = (count_q != '0);
    assign in_ready  = (count_q < DepthC) | bus.out_ready_i;
    assign push      = bus.in_valid_i & in_ready & ~bus.flush_i;
    assign pop       = out_valid & bus.out_ready_i & ~bus.flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stall_d  = stall_q;
        if (out_valid && !bus.out_ready_i && !bus.flush_i && stall_q != '1) begin
            stall_d = stall_q + 1'b1;
        end
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset) begin
                mem_q[i] <= '0;
            end else if (push && (DEPTH == 1 || wr_ptr_q == PtrW'(i))) begin
                mem_q[i] <= in_entry;
            end
        end
    end

    if (DEPTH == 1) begin : g_single
        assign head = mem_q[0];
    end else begin : g_multi
        assign head = mem_q[rd_ptr_q];
    end

    assign bus.in_ready_o              = in_ready;
    assign bus.out_valid_o             = out_valid;
    assign bus.EX_MEM_pc_4_o           = head.pc_4;
    assign bus.EX_MEM_pc_o             = head.pc;
    assign bus.EX_MEM_alu_result_o     = head.alu_result;
    assign bus.EX_MEM_write_data_o     = head.write_data;
    assign bus.EX_MEM_zero_o           = head.zero;
    assign bus.EX_MEM_write_register_o = head.write_register;
    assign bus.EX_MEM_mem_to_reg_o     = head.mem_to_reg;
    assign bus.EX_MEM_reg_write_o      = head.reg_write & out_valid;
    assign bus.EX_MEM_jalr_o           = head.jalr & out_valid;
    assign bus.EX_MEM_branch_o         = head.branch & out_valid;
    assign bus.EX_MEM_mem_read_o       = head.mem_read & out_valid;
    assign bus.EX_MEM_mem_write_o      = head.mem_write & out_valid;
    assign bus.EX_MEM_branch_taken_o   = head.branch_taken & out_valid;
    assign bus.stall_cnt_o             = stall_q;
endmodule

// File: tb/tb_ex_mem_stage_buf.sv
// Bench for ex_mem_stage_buf: scoreboard-checked DEPTH=2 instance plus a DEPTH=1, 2-bit
// stall counter instance for saturation.
module tb_ex_mem_stage_buf;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage_buf_if #(.NBits(32), .RegAddrW(5), .CntW(16)) m ();
    ex_mem_stage_buf_if #(.NBits(32), .RegAddrW(5), .CntW(2))  s ();

    ex_mem_stage_buf #(.NBits(32), .RegAddrW(5), .DEPTH(2), .CntW(16)) dut (
        .clk(clk), .reset(reset), .bus(m)
    );
    ex_mem_stage_buf #(.NBits(32), .RegAddrW(5), .DEPTH(1), .CntW(2)) dut1 (
        .clk(clk), .reset(reset), .bus(s)
    );

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  wr;
        logic        mw;
        logic        br;
        logic        tk;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] alu, input logic br, input logic zr,
                        input logic mw, input logic [4:0] wr, input logic tk);
        exp_t e;
        bit ok;
        ok = 1'b0;
        m.in_valid_i = 1'b1;
        m.alu_result_i = alu;
        m.ID_EX_pc_4_i = alu + 32'd4;
        m.pc_immediate_i = alu + 32'h100;
        m.ID_EX_read_2_i = ~alu;
        m.zero_i = zr;
        m.ID_EX_branch_i = br;
        m.ID_EX_mem_write_i = mw;
        m.ID_EX_write_register_i = wr;
        m.ID_EX_reg_write_i = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (m.in_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: in_ready_o stayed 0 for alu %h", alu);
        end else begin
            e.alu = alu; e.wr = wr; e.mw = mw; e.br = br; e.tk = tk;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 m.in_valid_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!reset && m.out_valid_o && m.out_ready_i && !m.flush_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got alu %h, expected no entry", m.EX_MEM_alu_result_o);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pop_alu", m.EX_MEM_alu_result_o, e.alu);
                chk("pop_pc4", m.EX_MEM_pc_4_o, e.alu + 32'd4);
                chk("pop_pc", m.EX_MEM_pc_o, e.alu + 32'h100);
                chk("pop_wdata", m.EX_MEM_write_data_o, ~e.alu);
                chk("pop_wreg", 32'(m.EX_MEM_write_register_o), 32'(e.wr));
                chk("pop_regwr", 32'(m.EX_MEM_reg_write_o), 32'd1);
                chk("pop_memwr", 32'(m.EX_MEM_mem_write_o), 32'(e.mw));
                chk("pop_branch", 32'(m.EX_MEM_branch_o), 32'(e.br));
                chk("pop_taken", 32'(m.EX_MEM_branch_taken_o), 32'(e.tk));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        m.in_valid_i = 1'b1; m.ID_EX_pc_4_i = 32'h44; m.pc_immediate_i = 32'h55;
        m.zero_i = 1'b1; m.alu_result_i = 32'hDEAD; m.ID_EX_read_2_i = 32'h66;
        m.ID_EX_write_register_i = 5'd7; m.ID_EX_reg_write_i = 1'b1; m.ID_EX_jalr_i = 1'b0;
        m.ID_EX_branch_i = 1'b1; m.ID_EX_mem_read_i = 1'b0; m.ID_EX_mem_write_i = 1'b1;
        m.ID_EX_mem_to_reg_i = 2'd0; m.flush_i = 1'b0; m.out_ready_i = 1'b0;
        s.in_valid_i = 1'b0; s.ID_EX_pc_4_i = '0; s.pc_immediate_i = '0; s.zero_i = 1'b0;
        s.alu_result_i = '0; s.ID_EX_read_2_i = '0; s.ID_EX_write_register_i = '0;
        s.ID_EX_reg_write_i = 1'b0; s.ID_EX_jalr_i = 1'b0; s.ID_EX_branch_i = 1'b0;
        s.ID_EX_mem_read_i = 1'b0; s.ID_EX_mem_write_i = 1'b0; s.ID_EX_mem_to_reg_i = 2'd0;
        s.flush_i = 1'b0; s.out_ready_i = 1'b1;

        // Reset held two edges with a valid input present
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        m.in_valid_i = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(m.out_valid_o), 32'd0);
        chk("rst_in_ready", 32'(m.in_ready_o), 32'd1);
        chk("rst_stall", 32'(m.stall_cnt_o), 32'd0);
        chk("rst_regwr", 32'(m.EX_MEM_reg_write_o), 32'd0);
        chk("rst_memwr", 32'(m.EX_MEM_mem_write_o), 32'd0);
        chk("rst_taken", 32'(m.EX_MEM_branch_taken_o), 32'd0);
        chk("rst_alu", m.EX_MEM_alu_result_o, 32'd0);
        chk("rst_d1_valid", 32'(s.out_valid_o), 32'd0);
        sync();

        // Streaming with MEM always ready: each entry drains the cycle after it lands
        m.out_ready_i = 1'b1;
        send(32'h10, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0);
        send(32'h20, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0);
        send(32'h30, 1'b0, 1'b0, 1'b0, 5'd3, 1'b0);
        @(negedge clk);
        chk("stream_last_visible", 32'(m.out_valid_o), 32'd1);
        @(negedge clk);
        chk("stream_drained", 32'(m.out_valid_o), 32'd0);
        sync();

        // Backpressure: A, B fill the buffer, C waits three cycles
        m.out_ready_i = 1'b0;
        send(32'h100, 1'b0, 1'b0, 1'b0, 5'd4, 1'b0);
        send(32'h200, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0);
        fork
            send(32'h300, 1'b0, 1'b0, 1'b0, 5'd6, 1'b0);
            begin
                @(negedge clk);
                chk("bp_full_in_ready", 32'(m.in_ready_o), 32'd0);
            end
            begin
                repeat (3) @(posedge clk);
                #1 m.out_ready_i = 1'b1;
                chk("bp_stall_cnt", 32'(m.stall_cnt_o), 32'd4);
            end
        join
        repeat (3) @(posedge clk);
        #1;

        // Flush while full of stores, with an incoming entry on the same edge
        m.out_ready_i = 1'b0;
        send(32'h400, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0);
        send(32'h500, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
        m.flush_i = 1'b1;
        m.in_valid_i = 1'b1;
        m.alu_result_i = 32'h600;
        m.ID_EX_mem_write_i = 1'b1;
        m.out_ready_i = 1'b1;
        @(posedge clk);
        #1 m.flush_i = 1'b0;
        m.in_valid_i = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_out_valid", 32'(m.out_valid_o), 32'd0);
        chk("flush_memwr", 32'(m.EX_MEM_mem_write_o), 32'd0);
        chk("flush_stall_kept", 32'(m.stall_cnt_o), 32'd5);
        sync();
        send(32'h700, 1'b0, 1'b0, 1'b0, 5'd10, 1'b0);

        // Branch resolution: taken only when branch and zero are both set
        send(32'h800, 1'b1, 1'b1, 1'b0, 5'd11, 1'b1);
        send(32'h900, 1'b1, 1'b0, 1'b0, 5'd12, 1'b0);
        send(32'hA00, 1'b0, 1'b1, 1'b0, 5'd13, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        // DEPTH=1, 2-bit counter: five stalled edges saturate at 3
        s.out_ready_i = 1'b0;
        s.in_valid_i = 1'b1;
        s.alu_result_i = 32'hABC;
        @(posedge clk);
        #1 s.in_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("d1_stall_sat", 32'(s.stall_cnt_o), 32'd3);
        chk("d1_full_in_ready", 32'(s.in_ready_o), 32'd0);
        chk("d1_out_valid", 32'(s.out_valid_o), 32'd1);
        chk("d1_alu", s.EX_MEM_alu_result_o, 32'hABC);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_mem_stage_buf.md
# ex_mem_stage_buf

Parametrised EX/MEM pipeline stage for the RV32 core: an elastic buffer of `DEPTH` entries carrying the EX-stage results and MEM/WB control bits into the MEM stage. It adds a valid/ready handshake, a pipeline flush, bubble-safe control gating, registered branch-taken resolution and a saturating stall counter. It sits between the ALU/branch-adder outputs and data memory, replacing the fixed single-register EX/MEM latch.

## Interface

Parameters:
- `NBits`, 32: data/address width.
- `RegAddrW`, 5: register-file address width.
- `DEPTH`, 2: entry count; any power of two ≥ 1.
- `CntW`, 16: stall counter width.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high; clears all state at the rising edge of `clk`.
- `in_valid_i`, input, 1: EX presents a valid instruction.
- `in_ready_o`, output, 1: stage accepts an entry this cycle.
- `ID_EX_pc_4_i`, input, `NBits`: PC+4.
- `pc_immediate_i`, input, `NBits`: branch/jump target.
- `zero_i`, input, 1: ALU zero flag.
- `alu_result_i`, input, `NBits`: ALU result / memory address.
- `ID_EX_read_2_i`, input, `NBits`: store data.
- `ID_EX_write_register_i`, input, `RegAddrW`: destination register.
- `ID_EX_reg_write_i`, `ID_EX_jalr_i`, `ID_EX_branch_i`, `ID_EX_mem_read_i`, `ID_EX_mem_write_i`, input, 1 each: control bits.
- `ID_EX_mem_to_reg_i`, input, 2: write-back select.
- `flush_i`, input, 1: discard all held and incoming entries.
- `out_ready_i`, input, 1: MEM consumes the head entry.
- `out_valid_o`, output, 1: head entry valid.
- `EX_MEM_pc_4_o`, `EX_MEM_pc_o`, `EX_MEM_alu_result_o`, `EX_MEM_write_data_o`, output, `NBits`: head data fields.
- `EX_MEM_zero_o`, output, 1; `EX_MEM_write_register_o`, output, `RegAddrW`; `EX_MEM_mem_to_reg_o`, output, 2: head fields.
- `EX_MEM_reg_write_o`, `EX_MEM_jalr_o`, `EX_MEM_branch_o`, `EX_MEM_mem_read_o`, `EX_MEM_mem_write_o`, output, 1 each: gated control bits.
- `EX_MEM_branch_taken_o`, output, 1: head is a taken branch.
- `stall_cnt_o`, output, `CntW`: cycles stalled by MEM.

## Operation

- Storage is a circular FIFO of `DEPTH` entries with a read pointer, a write pointer and an occupancy `count` (0..`DEPTH`, width log2(`DEPTH`)+1).
- `push = in_valid_i & in_ready_o & ~flush_i`; `pop = out_valid_o & out_ready_i & ~flush_i`.
- `in_ready_o = (count < DEPTH) | out_ready_i`. This gives a combinational path from `out_ready_i`; when the buffer is full, a push and a pop in the same cycle are allowed.
- When `count == 0`, `in_ready_o` is 1 regardless of `out_ready_i`.
- There is no bypass: an entry pushed at edge N appears on the outputs after edge N.
- `out_valid_o = (count != 0)`.
- Data outputs always show the head entry. Their contents are don't-care when `out_valid_o` is 0.
- Gated control outputs (`reg_write`, `jalr`, `branch`, `mem_read`, `mem_write`) are the head entry's bit ANDed with `out_valid_o`, so they are 0 for any bubble.
- `EX_MEM_branch_taken_o` is computed at push time as `branch & zero` and stored in the entry. It is presented through the same valid gating.
- Flush: on an edge where `flush_i` is 1, the FIFO empties (`count`←0, pointers←0) and any incoming entry is dropped. Flush has priority over push and pop. `stall_cnt_o` is unaffected.
- Stall counter: increments on every edge where `out_valid_o & ~out_ready_i & ~flush_i`. It saturates at all-ones and is cleared only by `reset`.
- Pointers wrap modulo `DEPTH`. With `DEPTH == 1` the pointers are constant 0.

## Timing

- Reset (synchronous, dominates all other inputs): `count`, pointers and `stall_cnt_o` go to 0, and all storage goes to 0.
- After reset, every output is 0 except `in_ready_o`, which is 1.
- Latency is 1 cycle from accepted input to visible output.
- Throughput is 1 entry per cycle while `out_ready_i` is held high, at any `DEPTH`.
- Empty with no push: outputs hold their previous data and control gating is 0.
- Full with `out_ready_i` = 0: `in_ready_o` = 0 and EX must hold its inputs.
- Full with `out_ready_i` = 1 and `in_valid_i` = 1: push and pop occur, `count` is unchanged, and the pointers advance together.
- Reset asserted mid-stream in the same cycle as a push or flush: reset wins and nothing is stored.

## Test plan

- Reset: hold `reset`=1 for 2 cycles with `in_valid_i`=1 -> after release, `out_valid_o`=0, all control outputs 0, `stall_cnt_o`=0, `in_ready_o`=1.
- Streaming with `DEPTH`=2 and `out_ready_i`=1: push ALU results 0x10, 0x20, 0x30 on consecutive cycles -> `EX_MEM_alu_result_o` shows 0x10, 0x20, 0x30 one cycle later each, and `count` never exceeds 1.
- Backpressure: `out_ready_i`=0, push A=0x100 then B=0x200 -> `in_ready_o` drops to 0 after B. A third input is held 3 cycles, during which `stall_cnt_o` reaches 4 (counting from A's first visible cycle). After `out_ready_i`=1, outputs are A, B, C in order.
- Flush: while holding 2 entries (`mem_write`=1), assert `flush_i` together with `in_valid_i` -> next cycle `out_valid_o`=0, `EX_MEM_mem_write_o`=0, the incoming entry is not present, and `stall_cnt_o` keeps its value.
- Branch resolution: push `branch`=1, `zero`=1, then `branch`=1, `zero`=0 -> `EX_MEM_branch_taken_o` is 1 then 0. With `DEPTH`=1 and `CntW`=2, stalling 5 cycles saturates `stall_cnt_o` at 3.
